// File: rtl/readout_pkg.sv
`default_nettype none
// ============================================================================
// Module   : readout_pkg
// Purpose  : Shared types and constants for the event buffer readout block:
//            FSM state encoding, header marker, sample/word/buffer geometry
//            and the header word builder.
// Revision : 1.0 - initial release
// ============================================================================
package readout_pkg;

    localparam int SAMPLE_W  = 768;
    localparam int WORD_W    = 32;
    localparam int BUF_DEPTH = 64;

    localparam logic [7:0] HDR_MARKER = 8'hEA;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SHIFT  = 3'd4
    } state_t;

    // Header word: marker, spare bit, sample count (1..64), event number.
    function automatic logic [WORD_W-1:0] make_header(input logic [6:0]  n_samp,
                                                      input logic [15:0] cnt);
        return {HDR_MARKER, 1'b0, n_samp, cnt};
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_readout.sv
`default_nettype none
// ============================================================================
// Module   : event_readout
// Purpose  : Reads a captured event out of a 64 x 768-bit event buffer and
//            streams it as 32-bit words with valid/ready handshaking. Each
//            event is one header word followed by 24 words per sample,
//            samples taken from address 63 downwards.
// Ports    : rd_clk, rst_n      - clock, async active-low reset
//            evt_ready, n_samples - event-complete pulse and sample count
//            read_addr, buf_data  - event buffer read port
//            dout, dout_valid, dout_ready, dout_last - output stream
//            busy, evt_cnt, drop_cnt - status
// Revision : 1.0 - initial release
// ============================================================================
module event_readout
    import readout_pkg::*;
#(
    parameter int RD_LATENCY       = 2,   // minimum 2 (FETCH + at least one WAIT)
    parameter int WORDS_PER_SAMPLE = 24
) (
    input  logic                rd_clk,
    input  logic                rst_n,
    input  logic                evt_ready,
    input  logic [5:0]          n_samples,
    output logic [5:0]          read_addr,
    input  logic [SAMPLE_W-1:0] buf_data,
    output logic [WORD_W-1:0]   dout,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic                dout_last,
    output logic                busy,
    output logic [15:0]         evt_cnt,
    output logic [7:0]          drop_cnt
);

    localparam logic [5:0] ADDR_TOP = 6'(BUF_DEPTH - 1);
    localparam logic [4:0] WAIT_END = 5'(RD_LATENCY - 2);
    localparam logic [4:0] WORD_END = 5'(WORDS_PER_SAMPLE - 1);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    state_t              r_state;
    state_t              w_state_next;
    logic [6:0]          r_n_lat;
    logic [6:0]          r_remaining;
    logic [4:0]          r_word_idx;
    logic [SAMPLE_W-1:0] r_shift;
    logic [5:0]          r_read_addr;
    logic [15:0]         r_evt_cnt;
    logic [7:0]          r_drop_cnt;
    logic                w_word_end;
    logic                w_final_sample;
    logic [6:0]          w_n_eff;

    // Reset asserts immediately but releases only after two clean edges.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // A request of 0 samples means a full buffer; the MSB carries the 64.
    assign w_n_eff        = {(n_samples == 6'd0), n_samples};
    assign w_word_end     = (r_word_idx == WORD_END);
    assign w_final_sample = (r_remaining == 7'd1);

    // Next-state and stream outputs
    always_comb begin
        w_state_next = r_state;
        dout         = '0;
        dout_valid   = 1'b0;
        dout_last    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (evt_ready) w_state_next = ST_HEADER;
            end
            ST_HEADER: begin
                dout       = make_header(r_n_lat, r_evt_cnt);
                dout_valid = 1'b1;
                if (dout_ready) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_word_idx == WAIT_END) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                dout       = r_shift[WORD_W-1:0];
                dout_valid = 1'b1;
                dout_last  = w_word_end && w_final_sample;
                if (dout_ready && w_word_end)
                    w_state_next = w_final_sample ? ST_IDLE : ST_FETCH;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_n_lat     <= 7'd0;
            r_remaining <= 7'd0;
            r_word_idx  <= 5'd0;
            r_shift     <= '0;
            r_read_addr <= ADDR_TOP;
            r_evt_cnt   <= 16'd0;
            r_drop_cnt  <= 8'd0;
        end else begin
            r_state <= w_state_next;

            // Any pulse outside IDLE is lost, including one coinciding with
            // the final transfer (state is still SHIFT on that edge).
            if (evt_ready && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (evt_ready) begin
                        r_n_lat     <= w_n_eff;
                        r_remaining <= w_n_eff;
                        r_read_addr <= ADDR_TOP;
                        r_evt_cnt   <= r_evt_cnt + 16'd1;
                        r_word_idx  <= 5'd0;
                    end
                end
                ST_FETCH: begin
                    // Word index doubles as the read-latency wait counter.
                    r_word_idx <= 5'd0;
                end
                ST_WAIT: begin
                    if (r_word_idx == WAIT_END) begin
                        r_shift    <= buf_data;
                        r_word_idx <= 5'd0;
                    end else begin
                        r_word_idx <= r_word_idx + 5'd1;
                    end
                end
                ST_SHIFT: begin
                    if (dout_ready) begin
                        r_shift <= r_shift >> WORD_W;
                        if (w_word_end) begin
                            r_word_idx <= 5'd0;
                            if (!w_final_sample) begin
                                r_remaining <= r_remaining - 7'd1;
                                r_read_addr <= r_read_addr - 6'd1;
                            end
                        end else begin
                            r_word_idx <= r_word_idx + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_addr = r_read_addr;
    assign busy      = (r_state != ST_IDLE);
    assign evt_cnt   = r_evt_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_event_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_readout
// Purpose  : Self-checking bench for event_readout. Expected words are queued
//            when an event is issued; monitors pop and compare on every
//            transfer. A second instance is built with RD_LATENCY=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_readout;
    import readout_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    // instance with default latency
    logic         evt_ready, dout_ready, dout_valid, dout_last, busy;
    logic [5:0]   n_samples, read_addr;
    logic [767:0] buf_data;
    logic [31:0]  dout;
    logic [15:0]  evt_cnt;
    logic [7:0]   drop_cnt;
    // instance with RD_LATENCY=3
    logic         evt_ready3, dout_ready3, dout_valid3, dout_last3, busy3;
    logic [5:0]   n_samples3, read_addr3;
    logic [767:0] buf_data3;
    logic [31:0]  dout3;
    logic [15:0]  evt_cnt3;
    logic [7:0]   drop_cnt3;

    exp_t q1[$];
    exp_t q3[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   xfers      = 0;
    int   lasts      = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    event_readout dut (
        .rd_clk(clk), .rst_n(rst_n), .evt_ready(evt_ready), .n_samples(n_samples),
        .read_addr(read_addr), .buf_data(buf_data), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy),
        .evt_cnt(evt_cnt), .drop_cnt(drop_cnt)
    );

    event_readout #(.RD_LATENCY(3)) dut3 (
        .rd_clk(clk), .rst_n(rst_n), .evt_ready(evt_ready3), .n_samples(n_samples3),
        .read_addr(read_addr3), .buf_data(buf_data3), .dout(dout3), .dout_valid(dout_valid3),
        .dout_ready(dout_ready3), .dout_last(dout_last3), .busy(busy3),
        .evt_cnt(evt_cnt3), .drop_cnt(drop_cnt3)
    );

    // Buffer contents: address 63 holds 0..23, address 62 holds 24..47, etc.
    function automatic logic [31:0] mem_word(input int a, input int w);
        return 32'((63 - a) * 24 + w);
    endfunction

    function automatic logic [767:0] mem_line(input logic [5:0] a);
        logic [767:0] line;
        for (int w = 0; w < 24; w++) line[w*32 +: 32] = mem_word(int'(a), w);
        return line;
    endfunction

    // Registered buffer models: RD_LATENCY-1 address stages each.
    logic [5:0] a1;
    logic [5:0] a3_0, a3_1;
    always @(posedge clk) begin
        a1   <= read_addr;
        a3_0 <= read_addr3;
        a3_1 <= a3_0;
    end
    always_comb buf_data  = mem_line(a1);
    always_comb buf_data3 = mem_line(a3_1);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_event(input int which, input logic [5:0] n, input logic [15:0] ec);
        logic [6:0] nl;
        exp_t e;
        nl = (n == 6'd0) ? 7'd64 : {1'b0, n};
        e.d = {8'hEA, 1'b0, nl, ec};
        e.l = 1'b0;
        if (which == 1) q1.push_back(e); else q3.push_back(e);
        for (int s = 0; s < int'(nl); s++) begin
            for (int w = 0; w < 24; w++) begin
                e.d = mem_word(63 - s, w);
                e.l = (s == int'(nl) - 1) && (w == 23);
                if (which == 1) q1.push_back(e); else q3.push_back(e);
            end
        end
    endtask

    task automatic pulse(input int which, input logic [5:0] n);
        @(negedge clk);
        if (which == 1) begin evt_ready = 1'b1; n_samples = n; end
        else            begin evt_ready3 = 1'b1; n_samples3 = n; end
        @(negedge clk);
        evt_ready  = 1'b0;
        evt_ready3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int c = 0;
        while (((which == 1) ? (q1.size() != 0 || busy) : (q3.size() != 0 || busy3))
               && c < budget) begin
            @(negedge clk);
            c++;
        end
        compared++;
        if (c >= budget) begin
            mismatched++;
            $display("FAIL timeout_%0d: waited %0d cycles, queue %0d/%0d left",
                     which, c, q1.size(), q3.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        q1.delete();
        q3.delete();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Randomised back-pressure, changed just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor for the default-latency instance: scoreboard plus stall hold.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    compared++;
                    if (!(dout_valid && dout == pd && dout_last == pl)) begin
                        mismatched++;
                        $display("FAIL stall_hold: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                                 dout_valid, dout, dout_last, pd, pl);
                    end
                end
                if (dout_valid && dout_ready) begin
                    xfers++;
                    if (dout_last) lasts++;
                    compared++;
                    if (q1.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_word: got %0h last=%0b expected none", dout, dout_last);
                    end else begin
                        e = q1.pop_front();
                        if (dout !== e.d || dout_last !== e.l) begin
                            mismatched++;
                            $display("FAIL word: got %0h last=%0b expected %0h last=%0b",
                                     dout, dout_last, e.d, e.l);
                        end
                    end
                end
                prev_stall = dout_valid && !dout_ready;
                pd = dout;
                pl = dout_last;
            end
        end
    end

    // Monitor for the RD_LATENCY=3 instance (never stalled).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dout_valid3 && dout_ready3) begin
                compared++;
                if (q3.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_word3: got %0h expected none", dout3);
                end else begin
                    e = q3.pop_front();
                    if (dout3 !== e.d || dout_last3 !== e.l) begin
                        mismatched++;
                        $display("FAIL word3: got %0h last=%0b expected %0h last=%0b",
                                 dout3, dout_last3, e.d, e.l);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n       = 1'b0;
        evt_ready   = 1'b0;
        evt_ready3  = 1'b0;
        n_samples   = 6'd0;
        n_samples3  = 6'd0;
        dout_ready  = 1'b1;
        dout_ready3 = 1'b1;
        do_reset();

        // Reset state
        chk("rst_read_addr", 32'(read_addr), 32'd63);
        chk("rst_dout",      dout,           32'd0);
        chk("rst_valid",     32'(dout_valid), 32'd0);
        chk("rst_last",      32'(dout_last),  32'd0);
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_evt_cnt",   32'(evt_cnt),    32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),   32'd0);

        // One sample, always ready
        xfers = 0;
        push_event(1, 6'd1, 16'd1);
        pulse(1, 6'd1);
        wait_done(1, 200);
        chk("n1_xfers",   32'(xfers),   32'd25);
        chk("n1_evt_cnt", 32'(evt_cnt), 32'd1);
        chk("n1_drop",    32'(drop_cnt), 32'd0);

        // One sample, random back-pressure
        rand_ready = 1'b1;
        push_event(1, 6'd1, 16'd2);
        pulse(1, 6'd1);
        wait_done(1, 500);
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        dout_ready = 1'b1;
        chk("rand_evt_cnt", 32'(evt_cnt), 32'd2);

        // Drops: one mid-readout, one coincident with the last transfer
        do_reset();
        push_event(1, 6'd2, 16'd1);
        pulse(1, 6'd2);
        repeat (10) @(negedge clk);
        pulse(1, 6'd5);
        c = 0;
        while (!(dout_valid && dout_last) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("last_seen", 32'(dout_valid && dout_last), 32'd1);
        evt_ready = 1'b1;
        n_samples = 6'd3;
        @(negedge clk);
        evt_ready = 1'b0;
        wait_done(1, 200);
        repeat (3) @(negedge clk);
        chk("drop_cnt",      32'(drop_cnt), 32'd2);
        chk("drop_evt_cnt",  32'(evt_cnt),  32'd1);
        chk("drop_busy_off", 32'(busy),     32'd0);

        // Full buffer (n_samples = 0 -> 64)
        do_reset();
        xfers = 0;
        lasts = 0;
        push_event(1, 6'd0, 16'd1);
        pulse(1, 6'd0);
        wait_done(1, 3000);
        chk("n64_xfers", 32'(xfers), 32'd1537);
        chk("n64_lasts", 32'(lasts), 32'd1);
        chk("n64_addr",  32'(read_addr), 32'd0);

        // Reset during sample 3 of 4
        do_reset();
        push_event(1, 6'd4, 16'd1);
        xfers = 0;
        pulse(1, 6'd4);
        c = 0;
        while (xfers < 60 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("mid_reached", 32'(xfers >= 60), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_dout",  dout,            32'd0);
        chk("mid_rst_last",  32'(dout_last),  32'd0);
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_addr",  32'(read_addr),  32'd63);
        chk("mid_rst_evt",   32'(evt_cnt),    32'd0);
        q1.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_event(1, 6'd1, 16'd1);
        pulse(1, 6'd1);
        wait_done(1, 200);
        chk("post_rst_evt", 32'(evt_cnt), 32'd1);

        // RD_LATENCY=3 instance, two samples
        push_event(3, 6'd2, 16'd1);
        pulse(3, 6'd2);
        wait_done(3, 300);
        chk("lat3_evt_cnt", 32'(evt_cnt3), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
